mem_stage: RTL and testbench

- Pipeline MEM stage, directly downstream of the EX stage; consumes the EX outputs (ALU result, store data, store/load controls, rd) and produces the MEM/WB register.
- Drives a variable-latency data-memory req/ack port, with a 2-state FSM for loads and stores.
- Performs store byte-lane alignment and load extraction with sign/zero extension.
- Stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage_if.sv | 30 +++
 rtl/mem_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/acknowledge bus between the MEM stage
// (master) and the data memory (slave).
//   dmem_req   master->slave  request strobe, held until dmem_ack
//   dmem_wr    master->slave  1 = store, 0 = load
//   dmem_addr  master->slave  word-aligned byte address
//   dmem_be    master->slave  byte enables
//   dmem_wdata master->slave  lane-aligned store data
//   dmem_ack   slave->master  request complete
//   dmem_rdata slave->master  load word, valid with dmem_ack
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_wr;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_wr, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_wr, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Takes the EX-stage outputs, performs loads
// and stores over a variable-latency req/ack data-memory bus, aligns store
// data to byte lanes, extracts/extends load data and produces the MEM/WB
// register.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   ex_*              EX-stage instruction fields (valid, PC, imm, ALU
//                     result/address, store data, sizes, sign, wb select, rd)
//   mem_stall         upstream must hold while an access is outstanding
//   dmem              data-memory bus (master side)
//   mem_*             MEM/WB register: valid pulse, rd, RF write enable,
//                     writeback data, misalignment trap flag
module mem_stage #(
  parameter int XLEN   = 32,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_PC,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rout,
  input  logic [XLEN-1:0]  ex_rv2,
  input  logic [3:0]       ex_reg_we,
  input  logic [3:0]       ex_mem_we,
  input  logic             ex_sign,
  input  logic [2:0]       ex_RFSrc,
  input  logic [4:0]       ex_rd,
  output logic             mem_stall,
  mem_stage_if.master      dmem,
  output logic             mem_valid,
  output logic [4:0]       mem_rd,
  output logic             mem_reg_we,
  output logic [XLEN-1:0]  mem_wdata,
  output logic             mem_misalign
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] SZ_BYTE = 4'b0001;
  localparam logic [3:0] SZ_HALF = 4'b0011;
  localparam logic [3:0] SZ_WORD = 4'b1111;

  localparam logic [2:0] SRC_ALU  = 3'd0;
  localparam logic [2:0] SRC_LOAD = 3'd1;
  localparam logic [2:0] SRC_PC   = 3'd2;
  localparam logic [2:0] SRC_IMM  = 3'd3;

  logic [0:0]      state_q, state_d;

  // Request registers: drive the bus and remember how to finish the access.
  logic            wr_q, wr_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      off_q, off_d;
  logic [3:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] rout_q, rout_d;

  // MEM/WB register.
  logic            mem_valid_q, mem_valid_d;
  logic [4:0]      mem_rd_q, mem_rd_d;
  logic            mem_reg_we_q, mem_reg_we_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            mem_misalign_q, mem_misalign_d;

  // Decode of the instruction currently presented by EX.
  logic            is_store;
  logic            is_mem;
  logic [3:0]      size_mask;
  logic [1:0]      ex_off;
  logic            misalign;
  logic [XLEN-1:0] alu_sel;
  logic [XLEN-1:0] load_shift;
  logic [XLEN-1:0] load_word;

  always_comb begin
    is_store  = |ex_mem_we;
    // Store wins when both store mask and load select are set.
    is_mem    = is_store || (ex_RFSrc == SRC_LOAD);
    size_mask = is_store ? ex_mem_we : ex_reg_we;
    ex_off    = ex_rout[1:0];
    misalign  = is_mem &&
                (((size_mask == SZ_HALF) && ex_off[0]) ||
                 ((size_mask == SZ_WORD) && (ex_off != 2'b00)));
  end

  always_comb begin
    case (ex_RFSrc)
      SRC_PC:  alu_sel = ex_PC + XLEN'(PC_INC);
      SRC_IMM: alu_sel = ex_imm;
      default: alu_sel = ex_rout;
    endcase
  end

  // Load extraction uses the lane offset captured at accept time.
  always_comb begin
    load_shift = dmem.dmem_rdata >> {off_q, 3'b000};
    load_word  = load_shift;
    case (size_q)
      SZ_BYTE: load_word = {{(XLEN-8){sign_q & load_shift[7]}}, load_shift[7:0]};
      SZ_HALF: load_word = {{(XLEN-16){sign_q & load_shift[15]}}, load_shift[15:0]};
      default: load_word = load_shift;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    off_d          = off_q;
    size_d         = size_q;
    sign_d         = sign_q;
    rd_d           = rd_q;
    rout_d         = rout_q;
    mem_valid_d    = 1'b0;
    mem_rd_d       = mem_rd_q;
    mem_reg_we_d   = mem_reg_we_q;
    mem_wdata_d    = mem_wdata_q;
    mem_misalign_d = mem_misalign_q;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (is_mem && !misalign) begin
            state_d = BUSY;
            wr_d    = is_store;
            addr_d  = {ex_rout[XLEN-1:2], 2'b00};
            be_d    = size_mask << ex_off;
            wdata_d = ex_rv2 << {ex_off, 3'b000};
            off_d   = ex_off;
            size_d  = size_mask;
            sign_d  = ex_sign;
            rd_d    = ex_rd;
            rout_d  = ex_rout;
          end else begin
            // Single-cycle path: ALU-class result or misalignment trap.
            mem_valid_d    = 1'b1;
            mem_rd_d       = ex_rd;
            mem_misalign_d = misalign;
            mem_reg_we_d   = misalign ? 1'b0 : (|ex_reg_we);
            mem_wdata_d    = misalign ? ex_rout : alu_sel;
          end
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          state_d        = IDLE;
          mem_valid_d    = 1'b1;
          mem_rd_d       = rd_q;
          mem_misalign_d = 1'b0;
          mem_reg_we_d   = wr_q ? 1'b0 : (|size_q);
          mem_wdata_d    = wr_q ? rout_q : load_word;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      be_q           <= '0;
      wdata_q        <= '0;
      off_q          <= '0;
      size_q         <= '0;
      sign_q         <= 1'b0;
      rd_q           <= '0;
      rout_q         <= '0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_reg_we_q   <= 1'b0;
      mem_wdata_q    <= '0;
      mem_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      off_q          <= off_d;
      size_q         <= size_d;
      sign_q         <= sign_d;
      rd_q           <= rd_d;
      rout_q         <= rout_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_reg_we_q   <= mem_reg_we_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_misalign_q <= mem_misalign_d;
    end
  end

  // Bus outputs come straight from registers, so they are stable for the
  // whole BUSY period; the strobe itself is the state.
  assign mem_stall       = (state_q == BUSY);
  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_wr    = wr_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  assign mem_valid    = mem_valid_q;
  assign mem_rd       = mem_rd_q;
  assign mem_reg_we   = mem_reg_we_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_misalign = mem_misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_PC;
  logic [31:0] ex_imm;
  logic [31:0] ex_rout;
  logic [31:0] ex_rv2;
  logic [3:0]  ex_reg_we;
  logic [3:0]  ex_mem_we;
  logic        ex_sign;
  logic [2:0]  ex_RFSrc;
  logic [4:0]  ex_rd;
  logic        mem_stall;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_reg_we;
  logic [31:0] mem_wdata;
  logic        mem_misalign;

  int errors = 0;
  int checks = 0;

  mem_stage_if #(.XLEN(32)) dmem ();

  mem_stage #(.XLEN(32), .PC_INC(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_PC        (ex_PC),
    .ex_imm       (ex_imm),
    .ex_rout      (ex_rout),
    .ex_rv2       (ex_rv2),
    .ex_reg_we    (ex_reg_we),
    .ex_mem_we    (ex_mem_we),
    .ex_sign      (ex_sign),
    .ex_RFSrc     (ex_RFSrc),
    .ex_rd        (ex_rd),
    .mem_stall    (mem_stall),
    .dmem         (dmem),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_reg_we   (mem_reg_we),
    .mem_wdata    (mem_wdata),
    .mem_misalign (mem_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid  = 1'b0;
    ex_PC     = '0;
    ex_imm    = '0;
    ex_rout   = '0;
    ex_rv2    = '0;
    ex_reg_we = '0;
    ex_mem_we = '0;
    ex_sign   = 1'b0;
    ex_RFSrc  = '0;
    ex_rd     = '0;
  endtask

  initial begin
    reset = 1'b1;
    clear_ex();
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    $display("txn reset");
    check("rst_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_req", {31'b0, dmem.dmem_req}, 32'd0);
    check("rst_stall", {31'b0, mem_stall}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rd", {27'b0, mem_rd}, 32'd0);

    // ALU passthrough
    ex_valid = 1'b1; ex_RFSrc = 3'd0; ex_rout = 32'h12345678; ex_rd = 5'd5; ex_reg_we = 4'b1111;
    step();
    clear_ex();
    $display("txn alu rout=12345678 wdata=%h", mem_wdata);
    check("alu_valid", {31'b0, mem_valid}, 32'd1);
    check("alu_wdata", mem_wdata, 32'h12345678);
    check("alu_rd", {27'b0, mem_rd}, 32'd5);
    check("alu_we", {31'b0, mem_reg_we}, 32'd1);
    check("alu_noreq", {31'b0, dmem.dmem_req}, 32'd0);
    check("alu_mis", {31'b0, mem_misalign}, 32'd0);
    step();
    check("alu_pulse", {31'b0, mem_valid}, 32'd0);
    check("alu_hold", mem_wdata, 32'h12345678);

    // Back-to-back: imm select then ALU select via RFSrc=5
    ex_valid = 1'b1; ex_RFSrc = 3'd3; ex_imm = 32'hDEADBEEF; ex_rout = 32'h11111111; ex_rd = 5'd9; ex_reg_we = 4'b1111;
    step();
    $display("txn imm wdata=%h", mem_wdata);
    check("imm_valid", {31'b0, mem_valid}, 32'd1);
    check("imm_wdata", mem_wdata, 32'hDEADBEEF);
    ex_RFSrc = 3'd5; ex_rout = 32'h0000_0042; ex_rd = 5'd10; ex_reg_we = 4'b0000;
    step();
    clear_ex();
    $display("txn src5 wdata=%h", mem_wdata);
    check("src5_valid", {31'b0, mem_valid}, 32'd1);
    check("src5_wdata", mem_wdata, 32'h00000042);
    check("src5_we", {31'b0, mem_reg_we}, 32'd0);
    check("src5_rd", {27'b0, mem_rd}, 32'd10);

    // Signed byte load, ack in the third BUSY cycle
    ex_valid = 1'b1; ex_rout = 32'h1003; ex_reg_we = 4'b0001; ex_sign = 1'b1; ex_RFSrc = 3'd1; ex_rd = 5'd7;
    step();
    clear_ex();
    check("lb_req", {31'b0, dmem.dmem_req}, 32'd1);
    check("lb_addr", dmem.dmem_addr, 32'h1000);
    check("lb_be", {28'b0, dmem.dmem_be}, 32'h8);
    check("lb_wr", {31'b0, dmem.dmem_wr}, 32'd0);
    check("lb_stall1", {31'b0, mem_stall}, 32'd1);
    step();
    check("lb_stall2", {31'b0, mem_stall}, 32'd1);
    check("lb_addr2", dmem.dmem_addr, 32'h1000);
    step();
    check("lb_stall3", {31'b0, mem_stall}, 32'd1);
    check("lb_novalid", {31'b0, mem_valid}, 32'd0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h80FFFFFF;
    step();
    dmem.dmem_ack = 1'b0;
    $display("txn lb addr=00001003 wdata=%h", mem_wdata);
    check("lb_valid", {31'b0, mem_valid}, 32'd1);
    check("lb_wdata", mem_wdata, 32'hFFFFFF80);
    check("lb_we", {31'b0, mem_reg_we}, 32'd1);
    check("lb_rd", {27'b0, mem_rd}, 32'd7);
    check("lb_stall_off", {31'b0, mem_stall}, 32'd0);
    check("lb_req_off", {31'b0, dmem.dmem_req}, 32'd0);

    // Unsigned half load, immediate ack (latency 2)
    ex_valid = 1'b1; ex_rout = 32'h2002; ex_reg_we = 4'b0011; ex_sign = 1'b0; ex_RFSrc = 3'd1; ex_rd = 5'd3;
    step();
    clear_ex();
    check("lhu_be", {28'b0, dmem.dmem_be}, 32'hC);
    check("lhu_addr", dmem.dmem_addr, 32'h2000);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hBEEF1234;
    step();
    dmem.dmem_ack = 1'b0;
    $display("txn lhu addr=00002002 wdata=%h", mem_wdata);
    check("lhu_valid", {31'b0, mem_valid}, 32'd1);
    check("lhu_wdata", mem_wdata, 32'h0000BEEF);

    // Signed half load at offset 0
    ex_valid = 1'b1; ex_rout = 32'h2100; ex_reg_we = 4'b0011; ex_sign = 1'b1; ex_RFSrc = 3'd1; ex_rd = 5'd4;
    step();
    clear_ex();
    check("lh_be", {28'b0, dmem.dmem_be}, 32'h3);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'h1234_8001;
    step();
    dmem.dmem_ack = 1'b0;
    $display("txn lh addr=00002100 wdata=%h", mem_wdata);
    check("lh_wdata", mem_wdata, 32'hFFFF8001);

    // Half store
    ex_valid = 1'b1; ex_rout = 32'h3002; ex_rv2 = 32'h0000ABCD; ex_mem_we = 4'b0011; ex_RFSrc = 3'd0; ex_rd = 5'd0;
    step();
    clear_ex();
    check("sh_wr", {31'b0, dmem.dmem_wr}, 32'd1);
    check("sh_be", {28'b0, dmem.dmem_be}, 32'hC);
    check("sh_wdata", dmem.dmem_wdata, 32'hABCD0000);
    check("sh_addr", dmem.dmem_addr, 32'h3000);
    dmem.dmem_ack = 1'b1;
    step();
    dmem.dmem_ack = 1'b0;
    $display("txn sh addr=00003002 be=%b", 4'b1100);
    check("sh_valid", {31'b0, mem_valid}, 32'd1);
    check("sh_we", {31'b0, mem_reg_we}, 32'd0);
    check("sh_wbdata", mem_wdata, 32'h00003002);

    // Misaligned word load
    ex_valid = 1'b1; ex_rout = 32'h4001; ex_reg_we = 4'b1111; ex_RFSrc = 3'd1; ex_rd = 5'd8;
    step();
    clear_ex();
    $display("txn lw-misaligned addr=00004001 mis=%b", mem_misalign);
    check("mis_req", {31'b0, dmem.dmem_req}, 32'd0);
    check("mis_valid", {31'b0, mem_valid}, 32'd1);
    check("mis_flag", {31'b0, mem_misalign}, 32'd1);
    check("mis_we", {31'b0, mem_reg_we}, 32'd0);
    check("mis_wdata", mem_wdata, 32'h00004001);
    check("mis_stall", {31'b0, mem_stall}, 32'd0);

    // Reset while BUSY, then a late ack
    ex_valid = 1'b1; ex_rout = 32'h5000; ex_reg_we = 4'b1111; ex_RFSrc = 3'd1; ex_rd = 5'd6;
    step();
    clear_ex();
    check("rb_req", {31'b0, dmem.dmem_req}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("txn reset-in-busy req=%b", dmem.dmem_req);
    check("rb_req_off", {31'b0, dmem.dmem_req}, 32'd0);
    check("rb_stall_off", {31'b0, mem_stall}, 32'd0);
    check("rb_valid", {31'b0, mem_valid}, 32'd0);
    dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 32'hCAFEF00D;
    step();
    dmem.dmem_ack = 1'b0;
    check("late_ack_valid", {31'b0, mem_valid}, 32'd0);
    check("late_ack_req", {31'b0, dmem.dmem_req}, 32'd0);

    // PC + 4 wraps
    ex_valid = 1'b1; ex_RFSrc = 3'd2; ex_PC = 32'hFFFFFFFC; ex_reg_we = 4'b1111; ex_rd = 5'd1;
    step();
    clear_ex();
    $display("txn pc pc=fffffffc wdata=%h", mem_wdata);
    check("pc_valid", {31'b0, mem_valid}, 32'd1);
    check("pc_wdata", mem_wdata, 32'h00000000);
    check("pc_rd", {27'b0, mem_rd}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
